// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic-array result path: FSM state type,
// default datapath widths and a signed saturation helper.
package tpu_pkg;

  localparam int DEF_MATRIX_SIZE    = 8;
  localparam int DEF_PARTIAL_SUM_BW = 20;
  localparam int DEF_ACC_BW         = 24;
  localparam int DEF_DATA_BW        = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Clamp a signed value to the range of a bw-bit two's complement number.
  // bw is always a constant at the call site, so this folds to comparators.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int bw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/requant_lane.sv
// Single-lane requantizer: arithmetic right shift of an accumulator value,
// optional ReLU, then saturation to the signed output width.
// Optional feature macro: RESULT_RELU_EN (negative shifted values clamp to 0).
module requant_lane
  import tpu_pkg::*;
#(
  parameter int ACC_BW  = DEF_ACC_BW,
  parameter int DATA_BW = DEF_DATA_BW
) (
  input  logic signed [ACC_BW-1:0]  acc,
  input  logic        [4:0]         shift,
  output logic        [DATA_BW-1:0] q
);

  logic signed [ACC_BW-1:0] shifted;
  logic signed [63:0]       widened;
  logic signed [63:0]       clipped;

  // Shift, optional ReLU, then clamp; a shift past the MSB leaves pure sign.
  // NOTE: every variable assigned in this block gets a value on every path,
  // otherwise synthesis infers a latch to hold the old one.
  always_comb begin
    shifted = acc >>> shift;
    widened = longint'(shifted);
`ifdef RESULT_RELU_EN
    if (widened < 64'sd0) widened = 64'sd0;
`else
    widened = widened;
`endif
    clipped = sat_signed(widened, DATA_BW);
    q       = DATA_BW'(clipped);
  end

endmodule

// File: rtl/result_accumulator_writeback.sv
// Result accumulator and Unified Buffer writeback. Accumulates de-skewed
// result rows across K-tiles into a MATRIX_SIZE x MATRIX_SIZE bank, then
// requantizes each row and writes it out over a ready/valid write port.
// Optional feature macro: RESULT_RELU_EN (ReLU before output saturation,
// applied inside requant_lane).
module result_accumulator_writeback
  import tpu_pkg::*;
#(
  parameter int MATRIX_SIZE    = DEF_MATRIX_SIZE,
  parameter int PARTIAL_SUM_BW = DEF_PARTIAL_SUM_BW,
  parameter int ACC_BW         = DEF_ACC_BW,
  parameter int DATA_BW        = DEF_DATA_BW,
  parameter int ADDRESSSIZE    = 10
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [ADDRESSSIZE-1:0]                base_addr,
  input  logic [7:0]                            num_tiles,
  input  logic [4:0]                            shift,
  input  logic                                  in_valid,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] in_data,
  output logic                                  ub_we,
  input  logic                                  ub_ready,
  output logic [ADDRESSSIZE-1:0]                ub_addr,
  output logic [DATA_BW*MATRIX_SIZE-1:0]        ub_wdata,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  drop_err,
  output logic                                  sat_err
);

  localparam int              RW       = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
  localparam logic [RW-1:0]   LAST_ROW = RW'(MATRIX_SIZE - 1);

  state_t                   state;
  logic [RW-1:0]            row_cnt;     // input row in ACCUM, output row in DRAIN
  logic [7:0]               tile_cnt;
  logic [7:0]               last_tile;
  logic [ADDRESSSIZE-1:0]   base_q;
  logic [4:0]               shift_q;

  logic signed [ACC_BW-1:0] acc [MATRIX_SIZE][MATRIX_SIZE];
  logic signed [ACC_BW-1:0] lane_ext  [MATRIX_SIZE];
  logic signed [63:0]       lane_sum  [MATRIX_SIZE];
  logic signed [63:0]       lane_clip [MATRIX_SIZE];
  logic signed [ACC_BW-1:0] acc_next  [MATRIX_SIZE];
  logic [MATRIX_SIZE-1:0]   lane_sat;

  logic                     accept_beat;
  logic [RW-1:0]            rq_row;
  logic [DATA_BW*MATRIX_SIZE-1:0] rq_data;

  assign accept_beat = (state == S_ACCUM) && in_valid;
  assign busy        = (state == S_ACCUM) || (state == S_DRAIN);

  // Next value of the row being written: load on the first tile, otherwise
  // saturating add of the sign-extended partial sums.
  always_comb begin
    for (int l = 0; l < MATRIX_SIZE; l++) begin
      lane_ext[l]  = ACC_BW'($signed(in_data[l*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]));
      lane_sum[l]  = longint'(acc[row_cnt][l]) + longint'(lane_ext[l]);
      lane_clip[l] = sat_signed(lane_sum[l], ACC_BW);
      lane_sat[l]  = (tile_cnt != 8'd0) && (lane_clip[l] != lane_sum[l]);
      acc_next[l]  = (tile_cnt == 8'd0) ? lane_ext[l] : ACC_BW'(lane_clip[l]);
    end
  end

  // Row fed to the requantizers is the one the write port presents next:
  // row 0 when leaving ACCUM, the following row while draining.
  always_comb begin
    rq_row = (state == S_DRAIN) ? row_cnt + RW'(1) : '0;
  end

  for (genvar l = 0; l < MATRIX_SIZE; l++) begin : g_lane
    requant_lane #(
      .ACC_BW  (ACC_BW),
      .DATA_BW (DATA_BW)
    ) u_requant (
      .acc   (acc[rq_row][l]),
      .shift (shift_q),
      .q     (rq_data[l*DATA_BW +: DATA_BW])
    );
  end

  // Accumulator bank write on every accepted result row.
  // NOTE: the bank is deliberately left out of reset; its contents are
  // overwritten on the first tile of every job, and resetting it would turn
  // a plain RAM-like array into a large reset network.
  always_ff @(posedge clk) begin
    if (accept_beat) begin
      for (int l = 0; l < MATRIX_SIZE; l++) begin
        acc[row_cnt][l] <= acc_next[l];
      end
    end
  end

  // Job control FSM with registered write port and status outputs.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      row_cnt   <= '0;
      tile_cnt  <= '0;
      last_tile <= '0;
      base_q    <= '0;
      shift_q   <= '0;
      ub_we     <= 1'b0;
      ub_addr   <= '0;
      ub_wdata  <= '0;
      done      <= 1'b0;
      drop_err  <= 1'b0;
      sat_err   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (in_valid && (state != S_ACCUM)) drop_err <= 1'b1;

      unique case (state)
        S_IDLE: begin
          if (start) begin
            base_q    <= base_addr;
            shift_q   <= shift;
            last_tile <= (num_tiles == 8'd0) ? 8'd0 : num_tiles - 8'd1;
            row_cnt   <= '0;
            tile_cnt  <= '0;
            drop_err  <= in_valid;  // a beat on the launch cycle is still dropped
            sat_err   <= 1'b0;
            state     <= S_ACCUM;
          end
        end

        S_ACCUM: begin
          if (in_valid) begin
            if (|lane_sat) sat_err <= 1'b1;
            if (row_cnt == LAST_ROW) begin
              row_cnt  <= '0;
              tile_cnt <= tile_cnt + 8'd1;
              if (tile_cnt == last_tile) begin
                state    <= S_DRAIN;
                ub_we    <= 1'b1;
                ub_addr  <= base_q;
                ub_wdata <= rq_data;
              end
            end else begin
              row_cnt <= row_cnt + RW'(1);
            end
          end
        end

        S_DRAIN: begin
          if (ub_ready) begin
            if (row_cnt == LAST_ROW) begin
              ub_we <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              row_cnt  <= row_cnt + RW'(1);
              ub_addr  <= ub_addr + ADDRESSSIZE'(1);
              ub_wdata <= rq_data;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_accumulator_writeback.sv
// Self-checking bench for result_accumulator_writeback. Expected writes are
// queued when a job is launched; a monitor pops and compares them whenever
// the DUT presents a write. Honors RESULT_RELU_EN for the negative cases.
`timescale 1ns/1ps
module tb_result_accumulator_writeback;

  localparam int MS  = 8;
  localparam int PSW = 20;
  localparam int DBW = 8;
  localparam int AW  = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic [7:0]        num_tiles;
  logic [4:0]        shift;
  logic              in_valid;
  logic [PSW*MS-1:0] in_data;
  logic              ub_we;
  logic              ub_ready;
  logic [AW-1:0]     ub_addr;
  logic [DBW*MS-1:0] ub_wdata;
  logic              busy;
  logic              done;
  logic              drop_err;
  logic              sat_err;

  result_accumulator_writeback dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_tiles (num_tiles),
    .shift     (shift),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .ub_we     (ub_we),
    .ub_ready  (ub_ready),
    .ub_addr   (ub_addr),
    .ub_wdata  (ub_wdata),
    .busy      (busy),
    .done      (done),
    .drop_err  (drop_err),
    .sat_err   (sat_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]     addr;
    logic [DBW*MS-1:0] data;
  } wr_t;

  wr_t        exp_q[$];
  int         n_tests  = 0;
  int         n_fail   = 0;
  int         done_cnt = 0;
  int         row_val  [MS];
  logic [7:0] exp_byte [MS];
  bit         toggle_mode = 1'b0;
  bit         hold_ready  = 1'b1;
  int         rdy_idx     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ub_ready driver: steady level, or the repeating pattern 1,0,0,1.
  initial begin
    ub_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (toggle_mode) begin
        ub_ready = ((rdy_idx % 4) == 0) || ((rdy_idx % 4) == 3);
        rdy_idx++;
      end else begin
        ub_ready = hold_ready;
      end
    end
  end

  // Monitor: every presented write must match the queue head, also while
  // stalled; the head is retired only when the write is accepted.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done) done_cnt++;
        if (ub_we) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", 64'(ub_we), 64'd0);
          end else begin
            e = exp_q[0];
            check("ub_addr", 64'(ub_addr), 64'(e.addr));
            check("ub_wdata", 64'(ub_wdata), 64'(e.data));
            if (ub_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // Launch a job whose row r carries row_val[r] in every lane on every tile;
  // the expected writes come from exp_byte[].
  task automatic run_job(input logic [AW-1:0] base, input logic [7:0] tiles,
                         input logic [4:0] sh, input bit wait_done);
    int             nt;
    int             d0;
    bit             seen;
    wr_t            w;
    logic [PSW-1:0] lv;
    nt = (tiles == 8'd0) ? 1 : int'(tiles);
    for (int r = 0; r < MS; r++) begin
      w.addr = base + AW'(r);
      w.data = {MS{exp_byte[r]}};
      exp_q.push_back(w);
    end
    d0        = done_cnt;
    start     = 1'b1;
    base_addr = base;
    num_tiles = tiles;
    shift     = sh;
    step();
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    for (int t = 0; t < nt; t++) begin
      for (int r = 0; r < MS; r++) begin
        in_valid = 1'b1;
        lv       = PSW'(row_val[r]);
        in_data  = {MS{lv}};
        step();
      end
    end
    in_valid = 1'b0;
    check("ub_we_after_last_beat", 64'(ub_we), 64'd1);
    if (wait_done) begin
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
        step();
        if (done_cnt != d0) seen = 1'b1;
      end
      check("done_timeout", 64'(seen), 64'd1);
      step();
      step();
      check("done_pulses", 64'(done_cnt - d0), 64'd1);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      check("busy_after_done", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    num_tiles = '0;
    shift     = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    step();
    step();
    check("rst_ub_we", 64'(ub_we), 64'd0);
    check("rst_ub_addr", 64'(ub_addr), 64'd0);
    check("rst_ub_wdata", 64'(ub_wdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_drop_err", 64'(drop_err), 64'd0);
    check("rst_sat_err", 64'(sat_err), 64'd0);
    rst = 1'b0;
    step();

    // One tile, row r = r*10, no shift.
    for (int r = 0; r < MS; r++) begin row_val[r] = r * 10; exp_byte[r] = 8'(r * 10); end
    run_job(10'd16, 8'd1, 5'd0, 1'b1);
    check("t1_sat_err", 64'(sat_err), 64'd0);

    // Three tiles of 100, shift 2 -> 300>>2 = 75.
    for (int r = 0; r < MS; r++) begin row_val[r] = 100; exp_byte[r] = 8'd75; end
    run_job(10'd100, 8'd3, 5'd2, 1'b1);
    check("t2_sat_err", 64'(sat_err), 64'd0);

    // 40 tiles of 524287 saturate the 24-bit accumulator -> output 127.
    for (int r = 0; r < MS; r++) begin row_val[r] = 524287; exp_byte[r] = 8'h7F; end
    run_job(10'd200, 8'd40, 5'd0, 1'b1);
    check("t3_sat_err", 64'(sat_err), 64'd1);

    // Negative lanes: -50 passes through, or clamps to 0 with ReLU.
    for (int r = 0; r < MS; r++) begin
      row_val[r] = -50;
`ifdef RESULT_RELU_EN
      exp_byte[r] = 8'h00;
`else
      exp_byte[r] = 8'hCE;
`endif
    end
    run_job(10'd300, 8'd1, 5'd0, 1'b1);

    // Shift beyond the accumulator width leaves only the sign.
    for (int r = 0; r < MS; r++) begin
      row_val[r] = (r < 4) ? -50 : 50;
`ifdef RESULT_RELU_EN
      exp_byte[r] = 8'h00;
`else
      exp_byte[r] = (r < 4) ? 8'hFF : 8'h00;
`endif
    end
    run_job(10'd400, 8'd1, 5'd24, 1'b1);

    // num_tiles = 0 behaves as a single tile.
    for (int r = 0; r < MS; r++) begin row_val[r] = 7; exp_byte[r] = 8'd7; end
    run_job(10'd500, 8'd0, 5'd0, 1'b1);

    // Address wrap with ub_ready stalling in the pattern 1,0,0,1.
    for (int r = 0; r < MS; r++) begin row_val[r] = r + 1; exp_byte[r] = 8'(r + 1); end
    toggle_mode = 1'b1;
    run_job(10'd1020, 8'd1, 5'd0, 1'b1);
    toggle_mode = 1'b0;
    step();

    // A beat while idle is dropped and flagged, with no write.
    in_valid = 1'b1;
    in_data  = {MS{20'h00123}};
    step();
    in_valid = 1'b0;
    step();
    check("drop_err_set", 64'(drop_err), 64'd1);
    check("drop_no_write", 64'(ub_we), 64'd0);
    check("drop_not_busy", 64'(busy), 64'd0);
    step();

    // Reset while the drain is stalled aborts the job.
    hold_ready = 1'b0;
    for (int r = 0; r < MS; r++) begin row_val[r] = r; exp_byte[r] = 8'(r); end
    run_job(10'd50, 8'd1, 5'd0, 1'b0);
    step();
    step();
    check("drain_stalled_we", 64'(ub_we), 64'd1);
    rst = 1'b1;
    step();
    check("abort_ub_we", 64'(ub_we), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_drop_err", 64'(drop_err), 64'd0);
    check("abort_ub_addr", 64'(ub_addr), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    hold_ready = 1'b1;
    step();

    // A fresh job after the abort runs normally.
    for (int r = 0; r < MS; r++) begin row_val[r] = r * 10; exp_byte[r] = 8'(r * 10); end
    run_job(10'd16, 8'd1, 5'd0, 1'b1);
    check("post_abort_drop_err", 64'(drop_err), 64'd0);
    check("post_abort_sat_err", 64'(sat_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
